// File: rtl/logic_capture_engine.sv
// Prescaled 16-channel logic capture: edge trigger, pre/post-trigger window in a
// circular buffer, oldest-first readout.
module logic_capture_engine #(
  parameter int DEPTH    = 512,
  parameter int PRE_TRIG = 128
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [28:0]      prescaling_factor,
  input  logic [15:0][1:0] trigger_kind,
  input  logic [15:0]      probe_in,
  input  logic             arm,
  input  logic             rd_en,
  output logic [15:0]      rd_data,
  output logic             rd_valid,
  output logic             rd_last,
  output logic             armed,
  output logic             triggered,
  output logic             done
);

  localparam int AW     = $clog2(DEPTH);
  localparam int POST_N = DEPTH - PRE_TRIG - 1;
  localparam logic [AW-1:0] PRE_OFF   = AW'(PRE_TRIG);
  localparam logic [AW-1:0] PRE_LAST  = AW'(PRE_TRIG - 1);
  localparam logic [AW-1:0] POST_LAST = AW'(POST_N - 1);
  localparam logic [AW:0]   RD_LAST   = (AW+1)'(DEPTH - 1);

  typedef enum logic [2:0] {S_IDLE, S_PRE, S_WAIT, S_POST, S_DONE} state_t;

  state_t      state;
  logic [15:0] sync1, sync2, cur;
  logic [28:0] pf_q, ps_cnt, ps_max;
  logic        pf_chg, tick;
  logic [15:0] hit;
  logic        hit_any, capturing, wr_en, rd_go, primed;
  logic [AW-1:0] wr_ptr, trig_ptr, rd_ptr, cnt;
  logic [AW:0]   rd_cnt;
  logic [15:0]   mem [DEPTH];

  // Prescaler: a change of factor restarts the count so a new rate takes effect cleanly.
  assign ps_max = (prescaling_factor == '0) ? '0 : prescaling_factor - 29'd1;
  assign pf_chg = (prescaling_factor != pf_q);
  assign tick   = !pf_chg && (ps_cnt >= ps_max);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pf_q   <= '0;
      ps_cnt <= '0;
      sync1  <= '0;
      sync2  <= '0;
      cur    <= '0;
    end else begin
      pf_q   <= prescaling_factor;
      ps_cnt <= (pf_chg || tick) ? '0 : ps_cnt + 29'd1;
      sync1  <= probe_in;
      sync2  <= sync1;
      if (tick) cur <= sync2;
    end
  end

  // Edges compare the sample taken this tick (sync2) with the previous one (cur).
  for (genvar i = 0; i < 16; i++) begin : g_edge
    assign hit[i] = (trigger_kind[i][0] & ~cur[i] &  sync2[i]) |
                    (trigger_kind[i][1] &  cur[i] & ~sync2[i]);
  end
  assign hit_any = (|hit) || (trigger_kind == '0);

  assign capturing = (state == S_PRE) || (state == S_WAIT) || (state == S_POST);
  assign wr_en     = tick && primed && !arm && capturing;
  assign rd_go     = rd_en && !arm && (state == S_DONE) && !rd_cnt[AW];

  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_ptr] <= sync2;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= S_IDLE;
      wr_ptr    <= '0;
      trig_ptr  <= '0;
      rd_ptr    <= '0;
      rd_cnt    <= '0;
      cnt       <= '0;
      primed    <= 1'b0;
      armed     <= 1'b0;
      triggered <= 1'b0;
      done      <= 1'b0;
    end else if (arm) begin
      state     <= S_PRE;
      wr_ptr    <= '0;
      trig_ptr  <= '0;
      rd_ptr    <= '0;
      rd_cnt    <= '0;
      cnt       <= '0;
      primed    <= 1'b0;
      armed     <= 1'b1;
      triggered <= 1'b0;
      done      <= 1'b0;
    end else begin
      // The first tick of a capture only establishes the edge reference.
      if (tick && capturing) primed <= 1'b1;
      if (wr_en) wr_ptr <= wr_ptr + 1'b1;
      if (rd_go) begin
        rd_ptr <= rd_ptr + 1'b1;
        rd_cnt <= rd_cnt + 1'b1;
      end
      if (wr_en) begin
        case (state)
          S_PRE: begin
            if (cnt == PRE_LAST) begin
              state <= S_WAIT;
              cnt   <= '0;
            end else begin
              cnt <= cnt + 1'b1;
            end
          end
          S_WAIT: begin
            if (hit_any) begin
              trig_ptr  <= wr_ptr;
              cnt       <= '0;
              triggered <= 1'b1;
              if (POST_N == 0) begin
                state  <= S_DONE;
                rd_ptr <= wr_ptr - PRE_OFF;
                armed  <= 1'b0;
                done   <= 1'b1;
              end else begin
                state <= S_POST;
              end
            end
          end
          S_POST: begin
            if (cnt == POST_LAST) begin
              state  <= S_DONE;
              rd_ptr <= trig_ptr - PRE_OFF;
              armed  <= 1'b0;
              done   <= 1'b1;
            end else begin
              cnt <= cnt + 1'b1;
            end
          end
          default: ;
        endcase
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_data  <= '0;
      rd_valid <= 1'b0;
      rd_last  <= 1'b0;
    end else begin
      rd_valid <= rd_go;
      rd_last  <= rd_go && (rd_cnt == RD_LAST);
      if (rd_go) rd_data <= mem[rd_ptr];
    end
  end

endmodule

// File: tb/tb_logic_capture_engine.sv
// Directed bench for logic_capture_engine (DEPTH=16, PRE_TRIG=4): table of
// capture scenarios plus re-arm and reset sequences.
module tb_logic_capture_engine;
  localparam int DEPTH  = 16;
  localparam int PRE    = 4;
  localparam int BUDGET = 400;

  logic             clk = 1'b0;
  logic             rst_n;
  logic [28:0]      prescaling_factor;
  logic [15:0][1:0] trigger_kind;
  logic [15:0]      probe_in;
  logic             arm, rd_en;
  logic [15:0]      rd_data;
  logic             rd_valid, rd_last, armed, triggered, done;

  int checks = 0;
  int errors = 0;

  logic_capture_engine #(.DEPTH(DEPTH), .PRE_TRIG(PRE)) dut (
    .clk(clk), .rst_n(rst_n), .prescaling_factor(prescaling_factor),
    .trigger_kind(trigger_kind), .probe_in(probe_in), .arm(arm), .rd_en(rd_en),
    .rd_data(rd_data), .rd_valid(rd_valid), .rd_last(rd_last),
    .armed(armed), .triggered(triggered), .done(done)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [28:0] pf;
    logic [31:0] kind;
    int          sel;        // probe pattern
    int          trig_step;  // pattern step that should become the trigger sample
    int          exp_trig;   // cycle triggered first seen, -1 = don't care
    int          exp_done;   // cycle done first seen, -1 = don't care
  } vec_t;

  vec_t vt[5];

  // Upper byte is a ramp (one step per sample period), lower byte holds trigger channels.
  function automatic logic [15:0] pat(input int sel, input int s);
    logic [7:0] r;
    logic [7:0] c;
    r = s[7:0];
    c = 8'h00;
    case (sel)
      0: c[0] = (s >= 12);
      1: c[5] = !((s >= 1 && s < 3) || s >= 10);
      default: c = 8'h00;
    endcase
    return {r, c};
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // Arm and drive the pattern until done or stop_c cycles; cycle c = negedge count after arm.
  task automatic capture(input vec_t v, input int stop_c, output int trig_c, output int done_c);
    int n;
    n = (v.pf == 0) ? 1 : int'(v.pf);
    trig_c = -1;
    done_c = -1;
    prescaling_factor = v.pf;
    trigger_kind = v.kind;
    probe_in = pat(v.sel, 0);
    repeat (4) @(negedge clk);
    arm = 1'b1;
    for (int c = 1; c <= stop_c; c++) begin
      @(negedge clk);
      arm = 1'b0;
      if (c % n == 0) probe_in = pat(v.sel, c / n);
      if (c == 1) begin
        chk("armed_after_arm", armed, 1);
        chk("trig_low_after_arm", triggered, 0);
        chk("done_low_after_arm", done, 0);
      end
      if (triggered && trig_c < 0) trig_c = c;
      if (done) begin
        done_c = c;
        break;
      end
    end
  endtask

  task automatic read_check(input int sel, input int first, input int k0, input int n);
    for (int k = 0; k < n; k++) begin
      rd_en = 1'b1;
      @(negedge clk);
      chk($sformatf("rd_valid[%0d]", k0 + k), rd_valid, 1);
      chk($sformatf("rd_data[%0d]", k0 + k), rd_data, pat(sel, first + k0 + k));
      chk($sformatf("rd_last[%0d]", k0 + k), rd_last, (k0 + k == DEPTH - 1) ? 1 : 0);
    end
    rd_en = 1'b0;
  endtask

  task automatic full_run(input vec_t v, input string tag);
    int tc, dc;
    capture(v, BUDGET, tc, dc);
    chk({tag, "_done_reached"}, (dc > 0) ? 1 : 0, 1);
    if (v.exp_trig >= 0) chk({tag, "_trig_cycle"}, tc, v.exp_trig);
    if (v.exp_done >= 0) chk({tag, "_done_cycle"}, dc, v.exp_done);
    chk({tag, "_armed_in_done"}, armed, 0);
    read_check(v.sel, v.trig_step - PRE, 0, DEPTH);
    rd_en = 1'b1;
    @(negedge clk);
    rd_en = 1'b0;
    chk({tag, "_read_past_depth"}, rd_valid, 0);
  endtask

  initial begin
    int tc, dc;
    vt[0] = '{pf: 29'd3, kind: 32'h1,   sel: 0, trig_step: 12, exp_trig: -1, exp_done: -1};
    vt[1] = '{pf: 29'd0, kind: 32'h1,   sel: 0, trig_step: 12, exp_trig: 15, exp_done: 26};
    vt[2] = '{pf: 29'd1, kind: 32'h1,   sel: 0, trig_step: 12, exp_trig: 15, exp_done: 26};
    vt[3] = '{pf: 29'd1, kind: 32'h800, sel: 1, trig_step: 10, exp_trig: 13, exp_done: 24};
    vt[4] = '{pf: 29'd1, kind: 32'h0,   sel: 2, trig_step: 4,  exp_trig: 7,  exp_done: 18};

    rst_n = 1'b0;
    prescaling_factor = 29'd1;
    trigger_kind = '0;
    probe_in = '0;
    arm = 1'b0;
    rd_en = 1'b0;
    repeat (3) @(negedge clk);
    chk("reset_outputs", {rd_data, rd_valid, rd_last, armed, triggered, done}, 0);
    rst_n = 1'b1;
    @(negedge clk);
    chk("idle_outputs", {rd_valid, armed, triggered, done}, 0);

    for (int i = 0; i < 5; i++) full_run(vt[i], $sformatf("vec%0d", i));

    // Re-arm during POSTTRIG, then again mid-readout with rd_en held.
    capture(vt[2], 17, tc, dc);
    chk("posttrig_triggered", triggered, 1);
    chk("posttrig_not_done", done, 0);
    capture(vt[4], BUDGET, tc, dc);
    chk("rearm1_done_cycle", dc, 18);
    read_check(2, 0, 0, 5);
    rd_en = 1'b1;
    arm = 1'b1;
    @(negedge clk);
    arm = 1'b0;
    rd_en = 1'b0;
    chk("rearm2_rd_valid", rd_valid, 0);
    chk("rearm2_done", done, 0);
    chk("rearm2_armed", armed, 1);
    full_run(vt[3], "rearm2");

    // Asynchronous reset in WAIT_TRIG.
    capture(vt[3], 8, tc, dc);
    chk("wait_armed", armed, 1);
    #2 rst_n = 1'b0;
    #1 chk("async_reset_outputs", {rd_data, rd_valid, rd_last, armed, triggered, done}, 0);
    @(negedge clk);
    rst_n = 1'b1;
    for (int k = 0; k < 3; k++) begin
      rd_en = 1'b1;
      @(negedge clk);
      chk($sformatf("post_reset_rd_valid[%0d]", k), rd_valid, 0);
      chk($sformatf("post_reset_done[%0d]", k), done, 0);
    end
    rd_en = 1'b0;
    full_run(vt[4], "after_reset");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout actual=running required=finished");
    $fatal(1, "timeout");
  end

endmodule
